// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-table sequencer: walks a case ROM and issues SCCB writes, NACK retries and ms delays.
// Optional build macro CFG_SOFT_RESET_EN: each run starts with COM7=0x80 and a RESET_WAIT_MS settle.
module ov7670_cfg_sequencer #(
  parameter int CLKS_PER_MS   = 100000,
  parameter int MAX_RETRY     = 3,
  parameter int RESET_WAIT_MS = 2
) (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [7:0] req_addr,
  output logic [7:0] req_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] entry_idx
);
  typedef enum logic [2:0] {
    S_IDLE, S_SRST, S_FETCH, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_FAIL
  } state_e;

  localparam int            TW        = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_MS - 1);
  localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRY);

  // {addr,data}; F0/xx = delay xx ms, FF/FF = end of table
  function automatic logic [15:0] rom(input logic [5:0] idx);
    case (idx)
      6'd0:    rom = 16'h1204;
      6'd1:    rom = 16'h8C02;
      6'd2:    rom = 16'h40D0;
      6'd3:    rom = 16'hF00A;
      6'd4:    rom = 16'h1101;
      default: rom = 16'hFFFF;
    endcase
  endfunction

  state_e        state_q;
  logic          start_q, srst_q, ret_q;
  logic [15:0]   ent_q;
  logic [5:0]    idx_q;
  logic [7:0]    retry_q, ms_q, addr_q, data_q;
  logic [TW-1:0] tick_q;
  logic          req_valid_q, busy_q, done_q, error_q;
  logic          start_rise;

  assign start_rise = start & ~start_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      srst_q      <= 1'b0;
      ret_q       <= 1'b0;
      ent_q       <= '0;
      idx_q       <= '0;
      retry_q     <= '0;
      ms_q        <= '0;
      tick_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            retry_q <= '0;
            ret_q   <= 1'b0;
`ifdef CFG_SOFT_RESET_EN
            req_valid_q <= 1'b1;
            addr_q      <= 8'h12;
            data_q      <= 8'h80;
            srst_q      <= 1'b1;
            state_q     <= S_SRST;
`else
            ent_q   <= rom(6'd0);
            state_q <= S_FETCH;
`endif
          end
        end
        S_FETCH: begin
          if (ent_q == 16'hFFFF) begin
            state_q <= S_DONE;
          end else if (ent_q[15:8] == 8'hF0) begin
            ms_q    <= ent_q[7:0];
            tick_q  <= '0;
            state_q <= S_DELAY;
          end else begin
            req_valid_q <= 1'b1;
            addr_q      <= ent_q[15:8];
            data_q      <= ent_q[7:0];
            state_q     <= S_ISSUE;
          end
        end
        S_SRST, S_ISSUE: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              retry_q <= '0;
              if (srst_q) begin
                srst_q  <= 1'b0;
                ret_q   <= 1'b1;
                ms_q    <= 8'(RESET_WAIT_MS);
                tick_q  <= '0;
                state_q <= S_DELAY;
              end else if (idx_q == 6'd63) begin
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_q + 6'd1;
                ent_q   <= rom(idx_q + 6'd1);
                state_q <= S_FETCH;
              end
            end else if (retry_q < RETRY_MAX) begin
              retry_q     <= retry_q + 8'd1;
              req_valid_q <= 1'b1;
              state_q     <= srst_q ? S_SRST : S_ISSUE;
            end else begin
              state_q <= S_FAIL;
            end
          end
        end
        S_DELAY: begin
          if (ms_q == 8'd0) begin
            // the post-reset settle returns to the current entry instead of advancing
            if (ret_q) begin
              ret_q   <= 1'b0;
              ent_q   <= rom(idx_q);
              state_q <= S_FETCH;
            end else if (idx_q == 6'd63) begin
              state_q <= S_DONE;
            end else begin
              idx_q   <= idx_q + 6'd1;
              ent_q   <= rom(idx_q + 6'd1);
              state_q <= S_FETCH;
            end
          end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            ms_q   <= ms_q - 8'd1;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_FAIL: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = addr_q;
  assign req_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign entry_idx = idx_q;

endmodule

// File: doc/ov7670_cfg_sequencer.md
# ov7670_cfg_sequencer

Sequences the OV7670 register configuration over SCCB after power-up or a user start. It sits between the debounced start control and the byte-level SCCB write master. It walks an internal register table, issues one write transaction per entry through a valid/ready request port, and inserts millisecond delays where the table requests them. It retries NACKed writes and reports completion or failure to the top level and the status LED.

## Interface
- `CLKS_PER_MS`, default 100000: `Clk` cycles per millisecond of delay.
- `MAX_RETRY`, default 3: extra attempts per entry after a NACK.
- `RESET_WAIT_MS`, default 2: wait after the soft reset write.
- `Clk` input, 1 bit: system clock (100 MHz); every flop is clocked on its rising edge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: level; a rising edge starts a configuration run.
- `req_valid` output, 1 bit: write request valid.
- `req_ready` input, 1 bit: the SCCB master accepts the request.
- `req_addr` output, 8 bits: register address.
- `req_data` output, 8 bits: register data.
- `rsp_valid` input, 1 bit: one-cycle pulse when the transaction completes.
- `rsp_nack` input, 1 bit: sampled with `rsp_valid`; 1 means the slave NACKed.
- `busy` output, 1 bit: a run is in progress.
- `done` output, 1 bit: sticky; the last run completed cleanly.
- `error` output, 1 bit: sticky; the last run aborted after exhausting its retries.
- `entry_idx` output, 6 bits: current table index, or the failing index after an abort.

## Operation
- The table is a synthesizable case ROM of 16-bit `{addr,data}` entries, with 64 entries maximum. The default contents are:
  - 0: 12/04
  - 1: 8C/02
  - 2: 40/D0
  - 3: F0/0A
  - 4: 11/01
  - 5: FF/FF
- Entry markers:
  - `addr=FF, data=FF`: end of table.
  - `addr=F0`: delay of `data` ms. A data value of 0 means no delay. No bus write is issued.
- States:
  - IDLE: on a `start` rising edge, clear `done`, `error` and `entry_idx`, set `busy`, then go to SRST (or FETCH when the macro is off).
  - SRST: present 12/80, then follow the ISSUE/WAIT behaviour. On success, load a delay of `RESET_WAIT_MS` and go to DELAY with return target FETCH.
  - FETCH: one cycle for the registered ROM read. Then:
    - end marker → DONE.
    - delay marker → DELAY.
    - anything else → ISSUE.
  - ISSUE: hold `req_valid=1` with `req_addr`/`req_data` stable. The request is accepted in the cycle where `req_valid && req_ready`; go to WAIT.
  - WAIT: on `rsp_valid`:
    - `!rsp_nack`: increment the index, clear the retry count, go to FETCH.
    - `rsp_nack` with retries < `MAX_RETRY`: increment the retry count, go to ISSUE.
    - otherwise: go to FAIL.
  - DELAY: a millisecond counter (`CLKS_PER_MS` cycles per tick) and an 8-bit ms counter. When the ms counter expires, increment the index and go to FETCH (or go to the return target).
  - DONE: `done=1`, `busy=0`, go to IDLE.
  - FAIL: `error=1`, `busy=0`, `entry_idx` frozen at the failing entry, go to IDLE.
- Boundary conditions:
  - A `start` edge is ignored while `busy` is high.
  - A stray `rsp_valid` outside WAIT is ignored.
  - `rsp_valid` arriving in the acceptance cycle is ignored.
  - If index 63 is reached with no end marker, the run goes to DONE after entry 63.
  - Asserting `reset_n=0` mid-run returns to IDLE immediately; `req_valid` drops asynchronously.

## Timing
- Reset values: `req_valid=0`, `req_addr=0`, `req_data=0`, `busy=0`, `done=0`, `error=0`, `entry_idx=0`, state IDLE, `start` edge detector cleared.
- `start` edge to `busy=1`: 1 cycle. To the first `req_valid`: 2 cycles with the macro off (via FETCH), 1 cycle with it on.
- Accepted write to the next `req_valid`: `rsp_valid` cycle + 2 (FETCH, then ISSUE).
- A delay entry of N ms holds the sequencer for N×`CLKS_PER_MS` cycles, ±2.
- Every output is registered; there are no combinational paths from input to output.

## Configuration
- `CFG_SOFT_RESET_EN`:
  - Defined: each run first writes COM7=0x80 (12/80) and waits `RESET_WAIT_MS` before table entry 0.
  - Undefined: SRST is unreachable, and the run starts directly at table entry 0.

## Test plan
Benches use `CLKS_PER_MS=10`, macro off unless noted.
- Clean run, `req_ready` always 1, response 5 cycles after accept → writes 12/04, 8C/02, 40/D0, then ≈100 idle cycles, then 11/01; `done=1`, `error=0`, `busy=0`, `entry_idx=5`.
- Backpressure, `req_ready` held low for 7 cycles on the first request → `req_valid` stays high; `req_addr=12` and `req_data=04` stay stable; exactly one accept.
- Entry 1 NACKs 3 times, then ACKs → 8C/02 is issued 4 times, and the run ends with `done=1`.
- Entry 2 NACKs 4 times → 40/D0 is issued 4 times; `error=1`, `done=0`, `entry_idx=2`, no further requests.
- Macro on → the first request is 12/80, and the 12/04 request is ≥20 cycles after that write's `rsp_valid`.
- `reset_n` pulsed low during DELAY, or `start` re-pulsed while busy:
  - reset: all outputs return to reset values at once, and a new `start` re-runs from entry 0.
  - start while busy: ignored.
